priority_encoder_reg: RTL and testbench
=======================================

Name: priority_encoder_reg

Overview:
- Registered N-to-log2(N) priority encoder. It is the inverse companion of the team's 2-to-4 one-hot decoder.
- It accepts a one-hot (or arbitrary) request word through a valid/ready handshake and returns the binary index of the highest set bit one cycle later.
- It flags non-one-hot inputs (more than one bit set, or no bit set).
- It sits between request sources and any consumer that needs a binary select, for example driving the decoder back to one-hot.

Parameters:
- WIDTH, 4, number of input request bits; must be ≥2 and a power of two.
- OUT_W, $clog2(WIDTH), localparam; width of the encoded index (2 at default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  block enable; when low, no new input is accepted and the output register holds.
- din  input  WIDTH  request word.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  block can accept din this cycle.
- dout  output  OUT_W  encoded index of the highest set bit of the accepted word.
- out_valid  output  1  dout, multi and none are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- multi  output  1  the accepted word had more than one bit set.
- none  output  1  the accepted word was all zero.

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, out_valid=0, multi=0, none=0, internal state=EMPTY. Reset takes effect immediately, including mid-transfer; any held result is discarded.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = en && (state==EMPTY || out_ready). This is combinational, so a single-register pipeline still sustains full throughput.
- Accept: in_valid && in_ready at a rising edge.
  - Registers dout = index of the highest set bit of din.
  - Registers multi = (popcount(din) > 1) and none = (din == 0).
  - Next state is FULL.
- Latency: 1 cycle from the accept edge to out_valid=1.
- Drain: out_valid && out_ready with no simultaneous accept → state EMPTY. dout, multi and none keep their last values (don't care while out_valid=0).
- Simultaneous drain and accept in FULL: new result loaded, state stays FULL; no bubble, no loss.
- Backpressure: FULL && !out_ready → dout, multi and none remain stable; in_ready=0.
- en low:
  - in_ready=0 and no accept occurs.
  - A result already in FULL can still drain via out_ready.
  - en does not clear state.
- All-zero input: dout=0, none=1, multi=0; the result is still delivered (not dropped).
- Priority: MSB wins, for example din=4'b0110 → dout=2, multi=1.
- Encoding of pure one-hot is the exact inverse of the 2-to-4 decoder: 0001→0, 0010→1, 0100→2, 1000→3.

Optional Feature:
- Macro: PRIO_ENC_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt [7:0], reset to 0.
  - err_cnt increments by 1 on each accepted word with multi or none set.
  - It saturates at 8'hFF and does not wrap.
  - It is cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package prio_enc_pkg: default WIDTH constant and a function to compute OUT_W.
- Sub-module prio_enc_comb: purely combinational; takes din and produces the index, multi and none. The top instantiates it and owns the handshake, state and registers.

Test Plan:
- Reset: assert rst_n=0 mid-FULL with dout=3 → dout=0, out_valid=0, multi=0 and none=0 immediately, without waiting for a clock edge.
- One-hot sweep, out_ready=1, en=1, din=0001, 0010, 0100, 1000 on consecutive cycles → dout=0, 1, 2, 3 one cycle later each, out_valid held 1, multi=0, none=0.
- Multi-hot and zero:
  - din=4'b1010 → dout=3, multi=1.
  - din=4'b0000 → dout=0, none=1, multi=0.
- Backpressure:
  - Accept din=0100, then out_ready=0 for 5 cycles while in_valid=1 with din=0001 → dout=2 stable, in_ready=0.
  - Then raise out_ready → 0001 accepted the same cycle, dout=0 next cycle.
- Enable: en=0 with in_valid=1, din=1000 → in_ready=0 and no new result; a prior result still drains when out_ready=1.
- PRIO_ENC_ERR_CNT_EN defined: 300 accepted zero words → err_cnt=8'hFF and stays there; one-hot words do not increment it.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg
// Shared definitions for the registered priority encoder:
//   DEFAULT_WIDTH - default request-word width
//   calc_out_w()  - width of the encoded index for a given request width
//   pe_state_t    - output-register occupancy state
package prio_enc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Index width for a WIDTH-bit request word. This is never less than 1,
    // so a degenerate width still gives a legal port.
    function automatic int unsigned calc_out_w(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } pe_state_t;

endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb
// Purely combinational priority encoder core.
// Ports:
//   din   [WIDTH-1:0] in  - request word
//   idx   [OUT_W-1:0] out - index of the highest set bit (0 when din is zero)
//   multi             out - more than one bit of din is set
//   none              out - din is all zero
module prio_enc_comb
    import prio_enc_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned OUT_W = calc_out_w(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    output logic [OUT_W-1:0] idx,
    output logic             multi,
    output logic             none
);

    // Scanning upward lets the highest set bit overwrite any lower ones,
    // so the MSB wins.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                idx = OUT_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        none  = (din == '0);
        multi = ((din & (din - 1'b1)) != '0);
    end

endmodule

// File: rtl/priority_encoder_reg.sv
// priority_encoder_reg
// Registered N-to-log2(N) priority encoder with a valid/ready handshake on
// both sides and a single output register.
// Optional feature macro: PRIO_ENC_ERR_CNT_EN adds the saturating err_cnt output.
// Ports:
//   clk        in  - system clock, rising edge
//   rst_n      in  - asynchronous active-low reset
//   en         in  - block enable; when low, no new word is accepted
//   din        in  - request word [WIDTH-1:0]
//   in_valid   in  - din valid
//   in_ready   out - block can accept din this cycle
//   dout       out - index of the highest set bit of the accepted word [OUT_W-1:0]
//   out_valid  out - dout/multi/none valid
//   out_ready  in  - consumer takes the output this cycle
//   multi      out - accepted word had more than one bit set
//   none       out - accepted word was zero
//   err_cnt    out - (PRIO_ENC_ERR_CNT_EN only) saturating count of multi/none words
module priority_encoder_reg
    import prio_enc_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned OUT_W = calc_out_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             multi,
    output logic             none
`ifdef PRIO_ENC_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    pe_state_t        state;
    logic [OUT_W-1:0] c_idx;
    logic             c_multi;
    logic             c_none;
    logic             accept;

    prio_enc_comb #(
        .WIDTH (WIDTH)
    ) u_core (
        .din   (din),
        .idx   (c_idx),
        .multi (c_multi),
        .none  (c_none)
    );

    // A full register that is being drained this cycle can take a new word,
    // which keeps one register at full throughput.
    assign in_ready  = en && ((state == ST_EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            dout  <= '0;
            multi <= 1'b0;
            none  <= 1'b0;
        end else begin
            if (accept) begin
                dout  <= c_idx;
                multi <= c_multi;
                none  <= c_none;
            end
            case (state)
                ST_EMPTY: if (accept) state <= ST_FULL;
                ST_FULL:  if (!accept && out_ready) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

`ifdef PRIO_ENC_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept && (c_multi || c_none) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_priority_encoder_reg.sv
module tb_priority_encoder_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] din;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] dout;
    logic       out_valid;
    logic       out_ready;
    logic       multi;
    logic       none;
`ifdef PRIO_ENC_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    priority_encoder_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .multi     (multi),
        .none      (none)
`ifdef PRIO_ENC_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the result slot as a queue of at most one entry.
    typedef struct {
        int idx;
        bit multi;
        bit none;
    } res_t;
    res_t slot[$];
    int   exp_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic res_t model(input logic [3:0] d);
        res_t r;
        int   v;
        int   ones;
        v = int'(d);
        r.idx = 0;
        while (v > 1) begin
            v = v / 2;
            r.idx++;
        end
        ones = 0;
        for (int b = 0; b < 4; b++) ones += int'(d[b]);
        r.multi = (ones > 1);
        r.none  = (ones == 0);
        return r;
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(slot.size() != 0));
        if (slot.size() != 0) begin
            check("dout",  32'(dout),  32'(slot[0].idx));
            check("multi", 32'(multi), 32'(slot[0].multi));
            check("none",  32'(none),  32'(slot[0].none));
        end
`ifdef PRIO_ENC_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input logic e, input logic [3:0] d, input logic iv, input logic ordy);
        bit   exp_rdy;
        res_t r;
        en = e; din = d; in_valid = iv; out_ready = ordy;
        #1;
        exp_rdy = e && (slot.size() == 0 || ordy);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (slot.size() != 0 && ordy) void'(slot.pop_front());
        if (iv && exp_rdy) begin
            r = model(d);
            slot.push_back(r);
            if ((r.multi || r.none) && exp_err < 255) exp_err++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_dout", 32'(dout), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_multi", 32'(multi), 0);
        check("rst_none", 32'(none), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while holding a result.
        step(1, 4'b1010, 1, 0);
        check("pre_rst_dout", 32'(dout), 3);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout), 0);
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_multi", 32'(multi), 0);
        check("async_rst_none", 32'(none), 0);
        slot.delete();
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // One-hot sweep at full throughput.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << i;
            step(1, oh, 1, 1);
            check("sweep_dout", 32'(dout), 32'(i));
            check("sweep_valid", 32'(out_valid), 1);
            check("sweep_multi", 32'(multi), 0);
        end

        step(1, 4'b1010, 1, 1);
        check("mh_dout", 32'(dout), 3);
        check("mh_multi", 32'(multi), 1);
        step(1, 4'b0000, 1, 1);
        check("zero_dout", 32'(dout), 0);
        check("zero_none", 32'(none), 1);
        check("zero_multi", 32'(multi), 0);

        // Backpressure.
        step(1, 4'b0100, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0001, 1, 0);
            check("bp_dout", 32'(dout), 2);
            check("bp_ready", 32'(in_ready), 0);
        end
        step(1, 4'b0001, 1, 1);
        check("bp_release_dout", 32'(dout), 0);
        check("bp_release_valid", 32'(out_valid), 1);

        // Enable low: prior result drains, nothing new accepted.
        step(0, 4'b1000, 1, 1);
        check("en_drain_valid", 32'(out_valid), 0);
        step(0, 4'b1000, 1, 1);
        check("en_idle_valid", 32'(out_valid), 0);

`ifdef PRIO_ENC_ERR_CNT_EN
        for (int i = 0; i < 300; i++) step(1, 4'b0000, 1, 1);
        check("err_sat", 32'(err_cnt), 32'hFF);
        for (int i = 0; i < 4; i++) step(1, 4'b0001 << i, 1, 1);
        check("err_hold", 32'(err_cnt), 32'hFF);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
